// File: rtl/ldtu_ofifo.sv
// ldtu_ofifo: output FIFO between the control unit and the serializer.
//
// Words written by the control unit are stored in order and popped one at a
// time into a registered output. When nothing is popped the output carries
// IdlePattern, so the serializer always has a valid word to send.
//
// Ports:
//   CLK           clock, rising edge
//   rst           asynchronous active-high reset
//   write_signal  write request; DATA_from_CU is stored if not full
//   DATA_from_CU  word to store
//   read_signal   pop request; DATA_out gets the oldest word if not empty
//   full          occupancy == FifoDepth_buff
//   empty         occupancy == 0
//   DATA_out      registered output word (IdlePattern when no pop)
//   occupancy     number of stored words, 0..FifoDepth_buff
//   drop_cnt      saturating count of writes rejected because the FIFO was full
module ldtu_ofifo #(
    parameter int unsigned Nbits_32       = 32,
    parameter int unsigned FifoDepth_buff = 64,
    parameter int unsigned bits_ptr       = 6,
    parameter logic [Nbits_32-1:0] IdlePattern = 32'hEAAAAAAA
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                write_signal,
    input  logic [Nbits_32-1:0] DATA_from_CU,
    input  logic                read_signal,
    output logic                full,
    output logic                empty,
    output logic [Nbits_32-1:0] DATA_out,
    output logic [bits_ptr:0]   occupancy,
    output logic [7:0]          drop_cnt
);

    localparam logic [bits_ptr:0] PtrOne = {{bits_ptr{1'b0}}, 1'b1};

    logic [Nbits_32-1:0] mem [FifoDepth_buff];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [bits_ptr:0]   wr_ptr_q, wr_ptr_d;
    logic [bits_ptr:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [Nbits_32-1:0] data_out_q, data_out_d;

    logic push;
    logic pop;
    logic drop;

    // Status decoded from the registered pointers, i.e. pre-edge values.
    always_comb begin
        full      = (wr_ptr_q[bits_ptr-1:0] == rd_ptr_q[bits_ptr-1:0]) &&
                    (wr_ptr_q[bits_ptr] != rd_ptr_q[bits_ptr]);
        empty     = (wr_ptr_q == rd_ptr_q);
        occupancy = wr_ptr_q - rd_ptr_q;
        DATA_out  = data_out_q;
        drop_cnt  = drop_cnt_q;
    end

    always_comb begin
        push       = write_signal && !full;
        drop       = write_signal && full;
        pop        = read_signal && !empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        data_out_d = IdlePattern;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PtrOne;
            data_out_d = mem[rd_ptr_q[bits_ptr-1:0]];
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            data_out_q <= IdlePattern;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately not reset; entries are only read after being written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q[bits_ptr-1:0]] <= DATA_from_CU;
        end
    end

endmodule

// File: doc/ldtu_ofifo.md
LDTU_OFIFO -- requirements
Module: ldtu_ofifo

Interface
REQ-001 Parameter Nbits_32, default 32: data word width.
REQ-002 Parameter FifoDepth_buff, default 64: storage depth in words.
REQ-003 Parameter bits_ptr, default 6: log2(FifoDepth_buff); pointers are bits_ptr+1 wide, MSB is the wrap bit.
REQ-004 Parameter IdlePattern, default 32'hEAAAAAAA: word driven when no data is popped.
REQ-005 CLK  input  1  single clock; all sequential logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 write_signal  input  1  write request from the control unit.
REQ-008 DATA_from_CU  input  Nbits_32  word to store, sampled when write_signal=1.
REQ-009 read_signal  input  1  pop request from the serializer side.
REQ-010 full  output  1  high when occupancy == FifoDepth_buff.
REQ-011 empty  output  1  high when occupancy == 0.
REQ-012 DATA_out  output  Nbits_32  registered output word.
REQ-013 occupancy  output  bits_ptr+1  number of stored words, 0..FifoDepth_buff.
REQ-014 drop_cnt  output  8  saturating count of rejected writes.

Function
REQ-015 full and empty SHALL be decoded combinationally from registered pointers: full when pointer LSBs are equal and wrap bits differ; empty when pointers are fully equal.
REQ-016 A write SHALL be accepted on a rising edge when write_signal=1 and full=0 (pre-edge value): mem[wr_ptr] <= DATA_from_CU, wr_ptr += 1.
REQ-017 A write with write_signal=1 and full=1 SHALL be dropped: memory and wr_ptr unchanged, drop_cnt += 1, saturating at 8'hFF.
REQ-018 A pop SHALL occur on a rising edge when read_signal=1 and empty=0 (pre-edge value): DATA_out <= mem[rd_ptr], rd_ptr += 1; latency is one cycle from read_signal to valid DATA_out.
REQ-019 On every edge without a pop, including read_signal=1 with empty=1, DATA_out SHALL load IdlePattern.
REQ-020 No fall-through: a word written while the FIFO is empty SHALL NOT appear on DATA_out before the next edge with read_signal=1.
REQ-021 Simultaneous accepted write and pop SHALL leave occupancy unchanged; accepted write only: +1; pop only: -1.
REQ-022 Simultaneous write and pop when full=1: the pop proceeds and the write is dropped (full is evaluated pre-edge), so occupancy becomes FifoDepth_buff-1.
REQ-023 Simultaneous write and read when empty=1: the write is accepted, DATA_out loads IdlePattern, and occupancy becomes 1.
REQ-024 Pointers SHALL wrap modulo 2*FifoDepth_buff; words SHALL be returned in write order across wrap-around.
REQ-025 occupancy SHALL equal wr_ptr - rd_ptr modulo 2*FifoDepth_buff and SHALL never exceed FifoDepth_buff.
REQ-026 Storage contents SHALL NOT be read or altered by dropped writes or by reads when empty.

Reset
REQ-027 With rst=1, asynchronously: wr_ptr=0, rd_ptr=0, occupancy=0, full=0, empty=1, DATA_out=IdlePattern, drop_cnt=0.
REQ-028 Memory array SHALL NOT be reset; its contents are unobservable until written.
REQ-029 Reset asserted mid-operation SHALL discard all stored words immediately; the first edge after deassertion behaves as from an empty FIFO.

Verification
REQ-030 Reset, then 3 idle cycles -> empty=1, full=0, occupancy=0, DATA_out=32'hEAAAAAAA, drop_cnt=0.
REQ-031 Write 32'h11111111, 32'h22222222, then read_signal=1 for 3 cycles -> DATA_out is 32'h11111111, 32'h22222222, then 32'hEAAAAAAA; empty=1 afterwards.
REQ-032 Write 64 words 0..63, then write 3 more -> full=1, occupancy=64, drop_cnt=3, and reading returns 0..63 in order.
REQ-033 With the FIFO full, apply write_signal=1 and read_signal=1 for one cycle -> occupancy=63, full=0, drop_cnt +1, DATA_out = oldest word.
REQ-034 Perform 200 writes interleaved with pops so that occupancy stays between 1 and 10 -> every word is read back in order across pointer wrap, and drop_cnt=0.
REQ-035 Store 5 words and assert rst for 1 cycle mid-stream -> occupancy=0, empty=1, DATA_out=IdlePattern; a subsequent read returns IdlePattern.
